shift_out: RTL

SHIFT_OUT -- requirements
Module: shift_out

---
 rtl/shift_out_if.sv | 32 +++
 rtl/shift_out.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/shift_out_if.sv
// Bus between a shift_out transmitter and its requester / external SIPO chain.
// Readback signals exist only when SHIFT_OUT_READBACK_EN is defined.
interface shift_out_if;
    logic [31:0] data;
    logic        go;
    logic        ready;
    logic        serial_data_out;
    logic        shift_clk;
    logic        latch_clk;
`ifdef SHIFT_OUT_READBACK_EN
    logic        serial_readback_in;
    logic [31:0] readback;
`endif

    modport master (
        output data, go,
        input  ready, serial_data_out, shift_clk, latch_clk
`ifdef SHIFT_OUT_READBACK_EN
        , output serial_readback_in,
        input  readback
`endif
    );

    modport slave (
        input  data, go,
        output ready, serial_data_out, shift_clk, latch_clk
`ifdef SHIFT_OUT_READBACK_EN
        , input serial_readback_in,
        output readback
`endif
    );
endinterface

// File: rtl/shift_out.sv
// Serialises a 32-bit word MSB first into an external SIPO shifter chain, then latches it.
// Optional feature macro: SHIFT_OUT_READBACK_EN (captures the chain's previous contents).
module shift_out (
    input  logic       clk,
    input  logic       rst,
    input  logic       action_pulse,
    input  logic       action_clk,
    shift_out_if.slave bus
);

    localparam logic [5:0] CNT_IDLE       = 6'd0;
    localparam logic [5:0] CNT_FIRST      = 6'd1;
    localparam logic [5:0] CNT_LAST_SHIFT = 6'd32;
    localparam logic [5:0] CNT_LATCH      = 6'd33;
    localparam logic [5:0] CNT_QUIET      = 6'd34;

    function automatic logic in_shift_window(input logic [5:0] cnt);
        return (cnt >= CNT_FIRST) && (cnt <= CNT_LAST_SHIFT);
    endfunction

    logic        active_r;
    logic [5:0]  cnt_r;
    logic [31:0] sreg_r;
    logic        ready_r;
    logic        sdo_r;
    logic        shift_clk_r;
    logic        latch_clk_r;

    logic        active_s;
    logic [5:0]  cnt_s;
    logic [31:0] sreg_s;
    logic        ready_s;
    logic        sdo_s;
    logic        shift_clk_s;
    logic        latch_clk_s;
    logic        start_s;
    logic        step_s;

    assign start_s = ready_r && bus.go;
    assign step_s  = active_r && action_pulse;

    // State register: activity flag, cycle counter and data shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= 1'b0;
            cnt_r    <= CNT_IDLE;
            sreg_r   <= 32'd0;
        end else begin
            active_r <= active_s;
            cnt_r    <= cnt_s;
            sreg_r   <= sreg_s;
        end
    end

    // Next-state logic: load on start, advance one step per action cycle while active.
    always_comb begin
        active_s = active_r;
        cnt_s    = cnt_r;
        sreg_s   = sreg_r;
        if (start_s) begin
            active_s = 1'b1;
            sreg_s   = bus.data;
        end else if (step_s) begin
            if (cnt_r == CNT_QUIET) begin
                cnt_s    = CNT_IDLE;
                active_s = 1'b0;
            end else begin
                cnt_s = cnt_r + 6'd1;
            end
            if (in_shift_window(cnt_r)) begin
                sreg_s = {sreg_r[30:0], 1'b0};
            end else begin
                sreg_s = sreg_r;
            end
        end else begin
            active_s = active_r;
        end
    end

    // Output decode. Chain clocks are forced low on pulse edges so each window
    // closes cleanly at the action-cycle boundary, never spilling into the next.
    always_comb begin
        ready_s = (cnt_s == CNT_IDLE) && !active_s;
        if (in_shift_window(cnt_s)) begin
            sdo_s = sreg_s[31];
        end else begin
            sdo_s = 1'b0;
        end
        if (in_shift_window(cnt_r) && !action_pulse) begin
            shift_clk_s = action_clk;
        end else begin
            shift_clk_s = 1'b0;
        end
        if ((cnt_r == CNT_LATCH) && !action_pulse) begin
            latch_clk_s = action_clk;
        end else begin
            latch_clk_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r     <= 1'b1;
            sdo_r       <= 1'b0;
            shift_clk_r <= 1'b0;
            latch_clk_r <= 1'b0;
        end else begin
            ready_r     <= ready_s;
            sdo_r       <= sdo_s;
            shift_clk_r <= shift_clk_s;
            latch_clk_r <= latch_clk_s;
        end
    end

    assign bus.ready           = ready_r;
    assign bus.serial_data_out = sdo_r;
    assign bus.shift_clk       = shift_clk_r;
    assign bus.latch_clk       = latch_clk_r;

`ifdef SHIFT_OUT_READBACK_EN
    logic [31:0] rb_r;
    logic [31:0] rb_s;

    // Readback capture. Sampled on the edges entering counts 1..32, i.e. before
    // each chain shift, so the old MSB is caught before it falls off the chain.
    always_comb begin
        if (start_s) begin
            rb_s = 32'd0;
        end else if (step_s && in_shift_window(cnt_s)) begin
            rb_s = {rb_r[30:0], bus.serial_readback_in};
        end else begin
            rb_s = rb_r;
        end
    end

    // Readback register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_r <= 32'd0;
        end else begin
            rb_r <= rb_s;
        end
    end

    assign bus.readback = rb_r;
`endif

endmodule
